cpu_controller: RTL and testbench
=================================

CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 SHALL have parameter: none; all encodings are fixed constants in the shared package.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  system clock; all state updates on posedge.
- Rst  in  1  reset, synchronous, active-high.
- IR  in  32  instruction register contents.
- NZCV  in  4  flags from the ALU/shifter datapath, [3]=N [2]=Z [1]=C [0]=V.
- ALU_OP  out  4  ALU operation code.
- SHIFT_OP  out  3  barrel shifter operation.
- ALU_A_s  out  1  A operand select: 1=PC, 0=register.
- ALU_B_s  out  1  B operand select: 1=sign-extended imm24<<2, 0=shifter output.
- LF  out  1  F result latch enable.
- S  out  1  NZCV latch enable.
- rm_imm_s  out  1  shift data select: 1=rotated imm8, 0=Rm.
- rs_imm_s  out  1  shift amount select: 1=Rs[7:0], 0=immediate field.
- IR_Write  out  1  load IR from instruction memory.
- PC_Write  out  1  load PC.
- PC_s  out  1  PC source: 0=PC+4, 1=F.
- LA_LB_LC  out  1  latch register-file read ports.
- Reg_Write  out  1  register-file write enable.
- Rd_s  out  1  write address: 0=IR[15:12], 1=R14.
- Wd_s  out  1  write data: 0=F, 1=PC.
- state  out  3  current FSM state, for debug.

Function
REQ-003 SHALL be a Moore FSM with states IDLE=0, FETCH=1, DECODE=2, EXEC_DP=3, WB=4, EXEC_B=5, LINK=6, PC_UPD=7; all outputs SHALL be decoded from state and IR only.
REQ-004 Outputs SHALL be 0 in every state unless listed below.
REQ-005 IDLE SHALL go unconditionally to FETCH.
REQ-006 FETCH: IR_Write=1, PC_Write=1, PC_s=0; next state DECODE.
REQ-007 DECODE: LA_LB_LC=1. SHALL evaluate IR[31:28] against NZCV: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 treated as fail.
REQ-008 DECODE: on condition fail, next state FETCH. On pass with IR[27:26]=00, next state EXEC_DP. On pass with IR[27:25]=101, next state EXEC_B. Any other class SHALL be treated as NOP and go to FETCH.
REQ-009 EXEC_DP control outputs:
- ALU_OP=IR[24:21]; LF=1; S=IR[20]; rm_imm_s=IR[25]; rs_imm_s=!IR[25]&IR[4].
- SHIFT_OP=111 (ROR) when IR[25]=1, else {IR[6:5],IR[4]}.
REQ-010 EXEC_DP: if IR[24:23]=10 (TST/TEQ/CMP/CMN) next state FETCH, else WB.
REQ-011 WB: Reg_Write=1, Rd_s=0, Wd_s=0; next state FETCH.
REQ-012 EXEC_B: ALU_A_s=1, ALU_B_s=1, ALU_OP=0100 (ADD), LF=1, S=0. Next state LINK if IR[24]=1 (BL), else PC_UPD.
REQ-013 LINK: Reg_Write=1, Rd_s=1, Wd_s=1; next state PC_UPD.
REQ-014 PC_UPD: PC_Write=1, PC_s=1; next state FETCH.
REQ-015 Per-instruction latency from FETCH entry: condition fail = 2 cycles; compare op = 3; DP with writeback = 4; B = 4; BL = 5.
REQ-016 S SHALL never assert outside EXEC_DP, so NZCV changes only from S-bit data-processing instructions.
REQ-017 IR SHALL be sampled combinationally in DECODE and EXEC states. IR changes are legal only in FETCH.

Reset
REQ-018 Rst=1 at a posedge SHALL force state IDLE and all outputs to 0 on the next cycle, from any state including mid-instruction. No partial PC or register write SHALL follow.
REQ-019 After Rst deasserts, the first FETCH SHALL occur exactly one cycle later.

Structure
REQ-020 State encodings, condition codes, ALU_OP ADD constant and SHIFT_OP ROR constant SHALL live in shared package cpu_pkg.
REQ-021 Condition evaluation SHALL be a separate combinational sub-module cond_check (inputs cond[3:0], NZCV; output pass).

Verification
REQ-022 Reset mid-EXEC_B -> state=0 and PC_Write=Reg_Write=0 next cycle; FETCH one cycle later.
REQ-023 IR=E2911001 (ADDS R1,R1,#1, cond AL) -> states 1,2,3,4,1; in EXEC_DP ALU_OP=0100, S=1, rm_imm_s=1, SHIFT_OP=111.
REQ-024 IR=0A000003 (BEQ) with NZCV=0000 -> states 1,2,1; no PC_Write outside FETCH.
REQ-025 IR=0A000003 with NZCV=0100 -> states 1,2,5,7,1; PC_s=1 in PC_UPD.
REQ-026 IR=EB000010 (BL) -> states 1,2,5,6,7,1; in LINK Rd_s=1, Wd_s=1, Reg_Write=1.
REQ-027 IR=E1500001 (CMP) -> states 1,2,3,1; S=1, Reg_Write never asserted. Repeat the sweep of all 16 conditions against all 16 NZCV values through cond_check.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU controller: FSM states, condition
// codes and the fixed ALU/shifter operation constants.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC_DP = 3'd3,
    S_WB      = 3'd4,
    S_EXEC_B  = 3'd5,
    S_LINK    = 3'd6,
    S_PC_UPD  = 3'd7
  } state_t;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam logic [3:0] ALU_ADD   = 4'b0100;
  localparam logic [2:0] SHIFT_ROR = 3'b111;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of an instruction condition field against NZCV.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] NZCV,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = NZCV;

  // The reserved 1111 encoding falls into the default and never passes.
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Moore FSM sequencing fetch, decode, data-processing and branch execution;
// every control output is decoded from the current state and IR.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        Rst,
  input  logic [31:0] IR,
  input  logic [3:0]  NZCV,
  output logic [3:0]  ALU_OP,
  output logic [2:0]  SHIFT_OP,
  output logic        ALU_A_s,
  output logic        ALU_B_s,
  output logic        LF,
  output logic        S,
  output logic        rm_imm_s,
  output logic        rs_imm_s,
  output logic        IR_Write,
  output logic        PC_Write,
  output logic        PC_s,
  output logic        LA_LB_LC,
  output logic        Reg_Write,
  output logic        Rd_s,
  output logic        Wd_s,
  output logic [2:0]  state
);

  state_t state_r, state_nx;
  logic   pass;
  logic   unused_ir;

  assign unused_ir = ^{IR[19:7], IR[3:0]};

  cond_check u_cond (
    .cond (IR[31:28]),
    .NZCV (NZCV),
    .pass (pass)
  );

  always_ff @(posedge clk) begin
    if (Rst) state_r <= S_IDLE;
    else     state_r <= state_nx;
  end

  assign state = state_r;

  always_comb begin
    state_nx  = state_r;
    ALU_OP    = '0;
    SHIFT_OP  = '0;
    ALU_A_s   = 1'b0;
    ALU_B_s   = 1'b0;
    LF        = 1'b0;
    S         = 1'b0;
    rm_imm_s  = 1'b0;
    rs_imm_s  = 1'b0;
    IR_Write  = 1'b0;
    PC_Write  = 1'b0;
    PC_s      = 1'b0;
    LA_LB_LC  = 1'b0;
    Reg_Write = 1'b0;
    Rd_s      = 1'b0;
    Wd_s      = 1'b0;
    case (state_r)
      S_IDLE: state_nx = S_FETCH;
      S_FETCH: begin
        IR_Write = 1'b1;
        PC_Write = 1'b1;
        state_nx = S_DECODE;
      end
      S_DECODE: begin
        LA_LB_LC = 1'b1;
        if (!pass)                  state_nx = S_FETCH;
        else if (IR[27:26] == 2'b00) state_nx = S_EXEC_DP;
        else if (IR[27:25] == 3'b101) state_nx = S_EXEC_B;
        else                        state_nx = S_FETCH;
      end
      S_EXEC_DP: begin
        ALU_OP   = IR[24:21];
        LF       = 1'b1;
        S        = IR[20];
        rm_imm_s = IR[25];
        rs_imm_s = !IR[25] & IR[4];
        SHIFT_OP = IR[25] ? SHIFT_ROR : {IR[6:5], IR[4]};
        // Test/compare opcodes only update flags, so they skip writeback.
        state_nx = (IR[24:23] == 2'b10) ? S_FETCH : S_WB;
      end
      S_WB: begin
        Reg_Write = 1'b1;
        state_nx  = S_FETCH;
      end
      S_EXEC_B: begin
        ALU_A_s  = 1'b1;
        ALU_B_s  = 1'b1;
        ALU_OP   = ALU_ADD;
        LF       = 1'b1;
        state_nx = IR[24] ? S_LINK : S_PC_UPD;
      end
      S_LINK: begin
        Reg_Write = 1'b1;
        Rd_s      = 1'b1;
        Wd_s      = 1'b1;
        state_nx  = S_PC_UPD;
      end
      S_PC_UPD: begin
        PC_Write = 1'b1;
        PC_s     = 1'b1;
        state_nx = S_FETCH;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: directed instructions, a full condition sweep and
// randomized instructions/resets checked against a behavioural model.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        Rst;
  logic [31:0] IR;
  logic [3:0]  NZCV;
  logic [3:0]  ALU_OP;
  logic [2:0]  SHIFT_OP;
  logic        ALU_A_s, ALU_B_s, LF, S, rm_imm_s, rs_imm_s;
  logic        IR_Write, PC_Write, PC_s, LA_LB_LC, Reg_Write, Rd_s, Wd_s;
  logic [2:0]  state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk(clk), .Rst(Rst), .IR(IR), .NZCV(NZCV),
    .ALU_OP(ALU_OP), .SHIFT_OP(SHIFT_OP), .ALU_A_s(ALU_A_s), .ALU_B_s(ALU_B_s),
    .LF(LF), .S(S), .rm_imm_s(rm_imm_s), .rs_imm_s(rs_imm_s),
    .IR_Write(IR_Write), .PC_Write(PC_Write), .PC_s(PC_s), .LA_LB_LC(LA_LB_LC),
    .Reg_Write(Reg_Write), .Rd_s(Rd_s), .Wd_s(Wd_s), .state(state)
  );

  wire [20:0] outs = {ALU_OP, SHIFT_OP, ALU_A_s, ALU_B_s, LF, S, rm_imm_s, rs_imm_s,
                      IR_Write, PC_Write, PC_s, LA_LB_LC, Reg_Write, Rd_s, Wd_s};

  // Conditions come in complementary pairs: cond[3:1] picks the base test and
  // cond[0] inverts it; pair 111 makes AL pass and 1111 fail.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  // Expected control word per state, packed in the same order as outs.
  function automatic logic [20:0] exp_out(input int st, input logic [31:0] ir);
    logic [3:0] alu; logic [2:0] sh;
    logic a, b, lf, s, rm, rs, irw, pcw, pcs, la, rw, rd, wd;
    {alu, sh, a, b, lf, s, rm, rs, irw, pcw, pcs, la, rw, rd, wd} = '0;
    case (st)
      1: begin irw = 1; pcw = 1; end
      2: la = 1;
      3: begin
        alu = ir[24:21]; lf = 1; s = ir[20]; rm = ir[25];
        rs = !ir[25] && ir[4];
        sh = ir[25] ? 3'b111 : ir[6:4];
      end
      4: rw = 1;
      5: begin a = 1; b = 1; alu = 4'b0100; lf = 1; end
      6: begin rw = 1; rd = 1; wd = 1; end
      7: begin pcw = 1; pcs = 1; end
      default: ;
    endcase
    return {alu, sh, a, b, lf, s, rm, rs, irw, pcw, pcs, la, rw, rd, wd};
  endfunction

  task automatic check_cycle(input int st, input logic [31:0] ir, input string tag);
    logic [20:0] eo;
    eo = exp_out(st, ir);
    vectors++;
    if (state !== 3'(st)) begin
      miscompares++;
      $display("FAIL %s state: got %0d want %0d (IR=%h)", tag, state, st, ir);
    end
    vectors++;
    if (outs !== eo) begin
      miscompares++;
      $display("FAIL %s outputs in state %0d: got %h want %h (IR=%h)", tag, st, outs, eo, ir);
    end
  endtask

  // Enters at a negedge where FETCH is expected; leaves at the next FETCH.
  // rst_at >= 0 asserts reset after that step of the instruction.
  task automatic run_instr(input logic [31:0] ir, input logic [3:0] f,
                           input int rst_at, input string tag);
    int seq[$];
    seq = '{1, 2};
    if (cond_ok(ir[31:28], f)) begin
      if (ir[27:26] == 2'b00) begin
        seq.push_back(3);
        if (ir[24:23] != 2'b10) seq.push_back(4);
      end else if (ir[27:25] == 3'b101) begin
        seq.push_back(5);
        if (ir[24]) seq.push_back(6);
        seq.push_back(7);
      end
    end
    IR = ir;
    NZCV = f;
    for (int i = 0; i < seq.size(); i++) begin
      if (i > 0) @(negedge clk);
      check_cycle(seq[i], ir, tag);
      if (i == rst_at) begin
        Rst = 1'b1;
        @(negedge clk);
        check_cycle(0, ir, {tag, "_rst"});
        Rst = 1'b0;
        @(negedge clk);
        check_cycle(1, ir, {tag, "_refetch"});
        return;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    Rst = 1'b1; IR = '0; NZCV = '0;
    repeat (2) @(negedge clk);
    check_cycle(0, IR, "reset");
    Rst = 1'b0;
    @(negedge clk);
    check_cycle(1, IR, "first_fetch");
  endtask

  task automatic test_directed;
    run_instr(32'hE2911001, 4'b0000, -1, "adds");
    run_instr(32'h0A000003, 4'b0000, -1, "beq_fail");
    run_instr(32'h0A000003, 4'b0100, -1, "beq_taken");
    run_instr(32'hEB000010, 4'b0000, -1, "bl");
    run_instr(32'hE1500001, 4'b0000, -1, "cmp");
    run_instr(32'hE0812003, 4'b0000, -1, "add_reg");
    run_instr(32'hE1A01312, 4'b0000, -1, "mov_rs_shift");
    run_instr(32'hF2911001, 4'b0100, -1, "cond_nv");
    run_instr(32'hE5912000, 4'b0000, -1, "ldr_nop");
  endtask

  task automatic test_reset_mid_branch;
    run_instr(32'hEA000004, 4'b0000, 2, "rst_exec_b");
    run_instr(32'hEB000004, 4'b0000, 3, "rst_link");
    run_instr(32'hE0812003, 4'b0000, 3, "rst_wb");
  endtask

  task automatic test_cond_sweep;
    for (int c = 0; c < 16; c++)
      for (int f = 0; f < 16; f++)
        run_instr({4'(c), 4'b1010, 24'h000003}, 4'(f), -1, "cond_sweep");
  endtask

  task automatic test_random;
    logic [31:0] ir;
    int rst_at;
    for (int k = 0; k < 400; k++) begin
      ir = $urandom;
      case ($urandom_range(0, 3))
        0: ir[27:26] = 2'b00;
        1: ir[27:25] = 3'b101;
        2: begin ir[31:28] = 4'hE; ir[27:26] = 2'b00; end
        default: ;
      endcase
      rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2)) : -1;
      run_instr(ir, 4'($urandom), rst_at, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_branch();
    test_cond_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
